// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-stage definitions: halt encodings, the queued (pc, instr)
// entry type, the default reset PC and a halt-word decode helper.
package fetch_buffer_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ECALL_INSTR      = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INSTR     = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue holding fetch_entry_t words between imem and decode.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   flush           synchronous clear of pointers and count (wins over push/pop)
//   push, push_data enqueue one entry; caller never pushes when full
//   pop             dequeue the head; ignored when empty
//   head            head entry, read combinationally from storage
//   count           entries held, 0..DEPTH
module fetch_fifo
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                // DEPTH is a power of two, so pointers wrap naturally.
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: PC generation, synchronous imem requests,
// prefetch queue towards decode, redirect handling and halt detection.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   imem_req/imem_addr          read request and word address (data next cycle)
//   imem_rdata                  read data for last cycle's request
//   redirect/redirect_pc        flush and restart fetch at redirect_pc (low bits dropped)
//   dec_valid/dec_ready         head handshake with decode
//   dec_pc/dec_instr            head entry
//   halt                        sticky; set once a halt word has been taken by decode
//   occupancy                   entries currently queued
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [31:0]            dec_pc,
    output logic [31:0]            dec_instr,
    output logic                   halt,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         inflight_q, inflight_d;
    logic         stopped_q, stopped_d;
    logic         halt_q, halt_d;
    // Low through reset and until the first edge after release, so the
    // first request lands in the cycle after that edge.
    logic         started_q, started_d;

    fetch_entry_t fifo_head, push_entry;
    logic [CW-1:0] fifo_count;
    logic          push, pop;
    logic [CW:0]   pending;

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        // Queued plus in-flight words; a same-cycle pop earns no credit.
        pending          = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        imem_req         = started_q && !redirect && !stopped_q && (pending < DEPTH_LIM);
        imem_addr        = fetch_pc_q;
        push             = inflight_q && !redirect && !stopped_q;
        push_entry.pc    = inflight_pc_q;
        push_entry.instr = imem_rdata;
        dec_valid        = (fifo_count != '0) && !redirect;
        pop              = dec_valid && dec_ready;

        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = inflight_q;
        stopped_d     = stopped_q;
        halt_d        = halt_q;
        started_d     = 1'b1;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            inflight_d = 1'b0;
            stopped_d  = 1'b0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 32'd4;
            end
            // The halt word itself is queued; everything after it is not.
            if (push && is_halt_instr(imem_rdata)) begin
                stopped_d = 1'b1;
            end
        end
        // A halt word is always the last queued entry, so the queue is
        // empty once it has been taken.
        if (pop && is_halt_instr(fifo_head.instr)) begin
            halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            stopped_q     <= 1'b0;
            halt_q        <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            stopped_q     <= stopped_d;
            halt_q        <= halt_d;
            started_q     <= started_d;
        end
    end

    assign dec_pc    = fifo_head.pc;
    assign dec_instr = fifo_head.instr;
    assign halt      = halt_q;
    assign occupancy = fifo_count;

endmodule

// File: tb/tb_fetch_buffer.sv
`timescale 1ns/1ps
module tb_fetch_buffer;

    localparam int          DEPTH  = 4;
    localparam int          OW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_instr;
    logic          halt;
    logic [OW-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    bit          halt_en   = 1'b0;
    logic [31:0] halt_addr = 32'h0;
    logic [31:0] halt_word = ECALL;

    fetch_buffer #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_instr(dec_instr),
        .halt(halt), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return halt_word;
        return a + 32'h1000;
    endfunction

    function automatic bit is_halt(input logic [31:0] w);
        return (w == ECALL) || (w == EBREAK);
    endfunction

    // Synchronous instruction memory; garbage when not requested so that
    // any stale capture shows up.
    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; dec_ready = 1'b1; redirect = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req c=%0d got %b exp 0", c, imem_req); end
            checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr c=%0d got %h exp %h", c, imem_addr, RST_PC); end
            checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid c=%0d got %b exp 0", c, dec_valid); end
            checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt c=%0d got %b exp 0", c, halt); end
            checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ c=%0d got %0d exp 0", c, occupancy); end
        end
    endtask

    task automatic test_stream();
        halt_en = 1'b0; dec_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL stream_req c=%0d got %b/%h exp 1/%h", c, imem_req, imem_addr, 32'(4 * c)); end
            checks++; if (dec_valid !== (c >= 2)) begin errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, dec_valid, c >= 2); end
            checks++; if (occupancy !== OW'(c >= 2 ? 1 : 0)) begin errors++; $display("FAIL stream_occ c=%0d got %0d", c, occupancy); end
            if (c >= 2) begin
                checks++; if (dec_pc !== 32'(4 * (c - 2))) begin errors++; $display("FAIL stream_pc c=%0d got %h exp %h", c, dec_pc, 32'(4 * (c - 2))); end
                checks++; if (dec_instr !== 32'(4 * (c - 2) + 32'h1000)) begin errors++; $display("FAIL stream_instr c=%0d got %h exp %h", c, dec_instr, 32'(4 * (c - 2) + 32'h1000)); end
            end
        end
    endtask

    task automatic test_stall();
        halt_en = 1'b0; dec_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk); dec_ready = (c >= 7); #1;
            checks++; if (imem_req !== ((c < 4) || (c >= 8))) begin errors++; $display("FAIL stall_req c=%0d got %b", c, imem_req); end
            if (c < 4) begin
                checks++; if (imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL stall_addr c=%0d got %h exp %h", c, imem_addr, 32'(4 * c)); end
            end
            if (c == 8) begin
                checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL stall_resume_addr got %h exp 10", imem_addr); end
            end
            if (c == 5 || c == 6) begin
                checks++; if (occupancy !== OW'(DEPTH)) begin errors++; $display("FAIL stall_full_occ c=%0d got %0d exp %0d", c, occupancy, DEPTH); end
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0) begin errors++; $display("FAIL stall_head c=%0d got %b/%h exp 1/0", c, dec_valid, dec_pc); end
            end
            if (c >= 7) begin
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (c - 7))) begin errors++; $display("FAIL stall_drain c=%0d got %b/%h exp 1/%h", c, dec_valid, dec_pc, 32'(4 * (c - 7))); end
                checks++; if (dec_instr !== 32'(4 * (c - 7) + 32'h1000)) begin errors++; $display("FAIL stall_instr c=%0d got %h", c, dec_instr); end
            end
        end
    endtask

    task automatic test_redirect();
        halt_en = 1'b0; dec_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); redirect = (c == 4); redirect_pc = 32'h103; dec_ready = (c >= 5); #1;
            if (c == 4) begin
                checks++; if (occupancy !== OW'(3)) begin errors++; $display("FAIL redir_pre_occ got %0d exp 3", occupancy); end
                checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL redir_same_cycle got req %b valid %b exp 0/0", imem_req, dec_valid); end
            end
            if (c == 5) begin
                checks++; if (occupancy !== '0) begin errors++; $display("FAIL redir_occ got %0d exp 0", occupancy); end
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %b/%h exp 1/100", imem_req, imem_addr); end
            end
            if (c == 5 || c == 6) begin
                checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_stale c=%0d got valid %b pc %h exp 0", c, dec_valid, dec_pc); end
            end
            if (c >= 7) begin
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(32'h100 + 4 * (c - 7))) begin errors++; $display("FAIL redir_pc c=%0d got %b/%h exp 1/%h", c, dec_valid, dec_pc, 32'(32'h100 + 4 * (c - 7))); end
                checks++; if (dec_instr !== 32'(32'h1100 + 4 * (c - 7))) begin errors++; $display("FAIL redir_instr c=%0d got %h", c, dec_instr); end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_halt();
        halt_en = 1'b1; halt_addr = 32'h8; halt_word = ECALL; dec_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); redirect = (c == 11); redirect_pc = 32'h300; #1;
            if (c < 4) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin errors++; $display("FAIL halt_req c=%0d got %b/%h", c, imem_req, imem_addr); end
            end
            if (c <= 4) begin
                checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_early c=%0d got %b exp 0", c, halt); end
            end
            if (c == 4) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_stop_req got %b exp 0", imem_req); end
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h8 || dec_instr !== ECALL) begin errors++; $display("FAIL halt_head got %b/%h/%h exp 1/8/73", dec_valid, dec_pc, dec_instr); end
            end
            if (c >= 5 && c <= 10) begin
                checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0 || occupancy !== '0) begin errors++; $display("FAIL halt_quiet c=%0d got req %b valid %b occ %0d", c, imem_req, dec_valid, occupancy); end
                checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_set c=%0d got %b exp 1", c, halt); end
            end
            if (c == 12) begin
                checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", halt); end
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL halt_resume got %b/%h exp 1/300", imem_req, imem_addr); end
            end
            if (c == 14) begin
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h300) begin errors++; $display("FAIL halt_resume_pc got %b/%h exp 1/300", dec_valid, dec_pc); end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_redirect_halt();
        halt_en = 1'b1; halt_addr = 32'h8; halt_word = EBREAK; dec_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk); redirect = (c == 3); redirect_pc = 32'h200; #1;
            checks++; if (halt !== 1'b0) begin errors++; $display("FAIL rh_halt c=%0d got %b exp 0", c, halt); end
            if (c == 3) begin
                checks++; if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin errors++; $display("FAIL rh_same got req %b valid %b exp 0/0", imem_req, dec_valid); end
            end
            if (c == 4) begin
                checks++; if (occupancy !== '0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rh_restart got occ %0d req %b addr %h exp 0/1/200", occupancy, imem_req, imem_addr); end
            end
            if (c >= 6) begin
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(32'h200 + 4 * (c - 6)) || dec_instr !== 32'(32'h1200 + 4 * (c - 6))) begin errors++; $display("FAIL rh_stream c=%0d got %b/%h/%h", c, dec_valid, dec_pc, dec_instr); end
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_midstream();
        halt_en = 1'b0; dec_ready = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        checks++; if (occupancy !== OW'(2)) begin errors++; $display("FAIL mid_pre_occ got %0d exp 2", occupancy); end
        reset = 1'b0; #1;
        checks++; if (dec_valid !== 1'b0 || occupancy !== '0 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_reset got valid %b occ %0d req %b exp 0/0/0", dec_valid, occupancy, imem_req); end
        @(negedge clk); reset = 1'b1; dec_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (c == 0) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/%h", imem_req, imem_addr, RST_PC); end
            end
            if (c == 2) begin
                checks++; if (dec_valid !== 1'b1 || dec_pc !== RST_PC || dec_instr !== 32'h1000) begin errors++; $display("FAIL mid_first got %b/%h/%h", dec_valid, dec_pc, dec_instr); end
            end
        end
    endtask

    // Reference model: words live in a queue; each cycle the issue rule,
    // response push, halt/stop rules and redirect flush are applied directly.
    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic [31:0] fpc, ipc, rpc, w;
        bit          infl, stp, hlt, rd, rdy, e_req, e_valid;
        halt_en = 1'b1; halt_addr = 32'h40; halt_word = EBREAK; dec_ready = 1'b1;
        do_reset();
        fpc = RST_PC; ipc = RST_PC; infl = 0; stp = 0; hlt = 0; q.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 127));
            redirect = rd; redirect_pc = rpc; dec_ready = rdy;
            #1;
            e_req   = !rd && !stp && (q.size() + int'(infl) < DEPTH);
            e_valid = (q.size() != 0) && !rd;
            checks++; if (imem_req !== e_req) begin errors++; $display("FAIL rnd_req c=%0d got %b exp %b", c, imem_req, e_req); end
            checks++; if (imem_addr !== fpc) begin errors++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, fpc); end
            checks++; if (dec_valid !== e_valid) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, dec_valid, e_valid); end
            checks++; if (occupancy !== OW'(q.size())) begin errors++; $display("FAIL rnd_occ c=%0d got %0d exp %0d", c, occupancy, q.size()); end
            checks++; if (halt !== hlt) begin errors++; $display("FAIL rnd_halt c=%0d got %b exp %b", c, halt, hlt); end
            if (e_valid) begin
                checks++; if (dec_pc !== q[0].pc || dec_instr !== q[0].instr) begin errors++; $display("FAIL rnd_head c=%0d got %h/%h exp %h/%h", c, dec_pc, dec_instr, q[0].pc, q[0].instr); end
            end
            if (rd) begin
                q.delete(); infl = 0; stp = 0; fpc = {rpc[31:2], 2'b00};
            end else begin
                if (e_valid && rdy) begin
                    e = q.pop_front();
                    if (is_halt(e.instr)) hlt = 1;
                end
                if (infl && !stp) begin
                    w = mem_word(ipc);
                    e.pc = ipc; e.instr = w;
                    q.push_back(e);
                    if (is_halt(w)) stp = 1;
                end
                infl = e_req;
                if (e_req) begin ipc = fpc; fpc = fpc + 32'd4; end
            end
        end
        redirect = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_redirect_halt();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch front end for the 5-stage pipeline. It generates the fetch PC, drives a synchronous instruction memory, and holds returned instructions in a small prefetch queue so decode can stall without losing fetched words. It accepts a redirect from the branch-resolving stage and stops fetching at a halt instruction. It produces the `(pc, instruction)` pair consumed by the decode pipeline register and the pipeline's `halt` indication.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: first fetch address after reset.
- `DEPTH`, `4`: queue entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  32  read address; word aligned.
- `imem_rdata`  in  32  read data, valid the cycle after `imem_req`.
- `redirect`  in  1  flush queue and restart fetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `dec_valid`  out  1  head entry available.
- `dec_ready`  in  1  decode accepts head (low = stall).
- `dec_pc`  out  32  PC of head entry.
- `dec_instr`  out  32  instruction of head entry.
- `halt`  out  1  sticky; halt instruction delivered to decode.
- `occupancy`  out  $clog2(DEPTH)+1  entries in queue.

## Operation
- State:
  - `fetch_pc`: reset value `RESET_PC`.
  - `inflight` (1 bit): a request was issued last cycle.
  - `inflight_pc`: PC of the in-flight request.
  - `stopped`: halt instruction seen.
  - `halt`.
  - Queue: `count`, read pointer, write pointer.
- Reset values: `imem_req=0` during reset, `imem_addr=RESET_PC`, `dec_valid=0`, `halt=0`, `occupancy=0`. All registers clear immediately on `reset` low, including mid-stream.
- Issue: `imem_req = !redirect && !stopped && (count + inflight < DEPTH)`.
  - Uses registered values only; no credit from a same-cycle pop.
  - On issue: `imem_addr = fetch_pc`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4` (32-bit wrap).
- Push: when `inflight && !redirect && !stopped`, enqueue `{inflight_pc, imem_rdata}`. A response arriving while `stopped` is dropped.
- Halt detect:
  - A pushed word equal to ECALL `32'h0000_0073` or EBREAK `32'h0010_0073` is enqueued normally.
  - It sets `stopped` at the same edge.
- Pop: `dec_valid = (count != 0) && !redirect`. The head is removed when `dec_valid && dec_ready`. Push and pop in the same cycle leave `count` unchanged.
- Halt output: `halt <= 1` at the edge where a halt instruction pops. It stays set until reset. After that pop, `dec_valid` stays 0, because the queue is empty by construction.
- Redirect (highest priority):
  - At the edge: `count`/pointers cleared, `inflight` cleared (the stale response next cycle is ignored), `stopped` cleared, `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - Same cycle: `imem_req=0`, no pop, no push.
  - Redirect in the same cycle as a halt push: the halt is discarded and fetch resumes.
- `halt` already set: a redirect does not clear it.

## Timing
- Reset release edge E0:
  - Cycle 0 after E0: `imem_req` with `RESET_PC`.
  - Cycle 1: data returns and is pushed.
  - Cycle 2: `dec_valid=1` with `dec_pc=RESET_PC`.
- Fetch-to-decode latency is 2 cycles. Redirect-to-first-valid latency is 3 cycles (redirect cycle, request, response).
- Sustained throughput is 1 instruction per cycle with `dec_ready=1` (steady state: `count=1`, `inflight=1`).
- Full: with `dec_ready=0`, exactly `DEPTH` requests are issued; `occupancy` saturates at `DEPTH`. Requests resume the cycle after the first pop.
- Empty: `dec_valid=0`, and `dec_pc`/`dec_instr` are don't-care.
- Pointers wrap modulo `DEPTH`.

## Structure
- Shared pipeline package holds:
  - `ECALL_INSTR` and `EBREAK_INSTR` constants.
  - `fetch_entry_t` struct `{pc[31:0], instr[31:0]}`.
  - `RESET_PC` default.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Depth `DEPTH`, synchronous `flush`, `push`/`pop`, `count`.
  - First-word visible combinationally from storage.
- PC, issue, halt and redirect logic sit in `fetch_buffer`.

## Test plan
- Stream: `RESET_PC=0`, `dec_ready=1`, memory returns `addr+32'h1000` → `dec_pc` 0, 4, 8, … on consecutive cycles from cycle 2, with `dec_instr = dec_pc+0x1000`.
- Stall: `dec_ready=0` from cycle 0 → exactly 4 requests (0x0–0xC), `occupancy=4`, `imem_req=0`. Raise `dec_ready` → 0x0–0xC drain in order, then 0x10 follows with no gap beyond 2 cycles.
- Redirect: `redirect=1`, `redirect_pc=0x103` with 3 entries queued and one in flight → next cycle `occupancy=0`, `imem_addr=0x100`, stale data never appears. First `dec_pc=0x100` 3 cycles after redirect.
- Halt: word 0x00000073 at 0x8 → no request beyond 0xC, response for 0xC dropped, `halt=1` the cycle after 0x8 is accepted, `dec_valid=0` thereafter.
- Redirect in the same cycle as the halt-word push → `halt` stays 0, fetch continues at `redirect_pc`.
- `reset` low mid-stream with queue 2/4 full → same cycle `dec_valid=0`, `occupancy=0`, `imem_req=0`. After release, fetch restarts at `RESET_PC`.
